// File: rtl/hazard_ctrl.sv
// hazard_ctrl
// Pipeline sequencing controller for the 5-stage core, sitting beside the
// forwarding unit. It handles the hazards that forwarding cannot cover:
// load-use, and branches whose operands are compared in ID. For these it
// inserts the right number of ID/EX bubbles. It also freezes the whole
// pipeline while data memory is busy, and flushes IF/ID on a taken branch.
// Three saturating performance counters track stall, bubble and flush events.
//
// Ports:
//   clk_i, rst_i          clock, asynchronous active-low reset
//   id_rs_i, id_rt_i      source register fields of the ID instruction
//   id_branch_i           ID instruction is a branch resolved in ID
//   branch_taken_i        ID branch comparator result
//   ex_memread_i          EX instruction is a load
//   ex_regwrite_i         EX instruction writes a register
//   ex_rd_i               EX destination register
//   mem_memread_i         MEM instruction is a load
//   mem_rd_i              MEM destination register
//   dmem_stall_i          data memory busy, freeze the pipeline
//   clr_cnt_i             synchronous clear of the perf counters
//   pc_write_o            PC update enable
//   ifid_write_o          IF/ID write enable
//   ifid_flush_o          IF/ID loads a NOP
//   idex_bubble_o         ID/EX loads a control-zero bubble
//   pipe_stall_o          freeze ID/EX, EX/MEM and MEM/WB
//   stall_cnt_o           cycles with dmem_stall_i asserted
//   bubble_cnt_o          bubbles inserted
//   flush_cnt_o           IF/ID flushes issued

module hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       id_rs_i,
  input  logic [4:0]       id_rt_i,
  input  logic             id_branch_i,
  input  logic             branch_taken_i,
  input  logic             ex_memread_i,
  input  logic             ex_regwrite_i,
  input  logic [4:0]       ex_rd_i,
  input  logic             mem_memread_i,
  input  logic [4:0]       mem_rd_i,
  input  logic             dmem_stall_i,
  input  logic             clr_cnt_i,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic             ifid_flush_o,
  output logic             idex_bubble_o,
  output logic             pipe_stall_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] bubble_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  // STALL means one further bubble is still owed to a load feeding a branch.
  typedef enum logic {RUN, STALL} state_t;

  state_t state, state_next;

  logic ex_match, mem_match;
  logic lu, bex, bmem, hazard;
  logic stall_ev, bubble_ev, flush_ev;

  // Register 0 never produces a dependency.
  assign ex_match  = (ex_rd_i  != 5'd0) && ((ex_rd_i  == id_rs_i) || (ex_rd_i  == id_rt_i));
  assign mem_match = (mem_rd_i != 5'd0) && ((mem_rd_i == id_rs_i) || (mem_rd_i == id_rt_i));

  assign lu     = ex_memread_i && ex_match;
  assign bex    = id_branch_i && ex_regwrite_i && !ex_memread_i && ex_match;
  assign bmem   = id_branch_i && mem_memread_i && mem_match;
  assign hazard = lu || bex || bmem;

  // State register; a reset in STALL discards the owed bubble.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= RUN;
    else        state <= state_next;
  end

  // Next state: a memory freeze holds the state so an owed bubble survives;
  // only a load feeding a branch needs the second bubble.
  always_comb begin
    state_next = state;
    if (dmem_stall_i)            state_next = state;
    else if (state == STALL)     state_next = RUN;
    else if (lu && id_branch_i)  state_next = STALL;
    else                         state_next = RUN;
  end

  // Mealy outputs and counter events. While reset is held the outputs are
  // forced to a safe "bubble and flush, no writes" pattern regardless of inputs.
  always_comb begin
    pc_write_o    = 1'b1;
    ifid_write_o  = 1'b1;
    ifid_flush_o  = 1'b0;
    idex_bubble_o = 1'b0;
    pipe_stall_o  = 1'b0;
    stall_ev      = 1'b0;
    bubble_ev     = 1'b0;
    flush_ev      = 1'b0;
    if (!rst_i) begin
      pc_write_o    = 1'b0;
      ifid_write_o  = 1'b0;
      ifid_flush_o  = 1'b1;
      idex_bubble_o = 1'b1;
    end else if (dmem_stall_i) begin
      pipe_stall_o  = 1'b1;
      pc_write_o    = 1'b0;
      ifid_write_o  = 1'b0;
      stall_ev      = 1'b1;
    end else if (state == STALL) begin
      pc_write_o    = 1'b0;
      ifid_write_o  = 1'b0;
      idex_bubble_o = 1'b1;
      bubble_ev     = 1'b1;
    end else if (hazard) begin
      // Branch operands are not valid yet, so branch_taken_i is ignored here.
      pc_write_o    = 1'b0;
      ifid_write_o  = 1'b0;
      idex_bubble_o = 1'b1;
      bubble_ev     = 1'b1;
    end else if (id_branch_i && branch_taken_i) begin
      ifid_flush_o  = 1'b1;
      flush_ev      = 1'b1;
    end
  end

  // Saturating counters; clear wins over a same-cycle increment.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_o  <= '0;
      bubble_cnt_o <= '0;
      flush_cnt_o  <= '0;
    end else if (clr_cnt_i) begin
      stall_cnt_o  <= '0;
      bubble_cnt_o <= '0;
      flush_cnt_o  <= '0;
    end else begin
      if (stall_ev  && (stall_cnt_o  != '1)) stall_cnt_o  <= stall_cnt_o  + 1'b1;
      if (bubble_ev && (bubble_cnt_o != '1)) bubble_cnt_o <= bubble_cnt_o + 1'b1;
      if (flush_ev  && (flush_cnt_o  != '1)) flush_cnt_o  <= flush_cnt_o  + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl
// Directed test of hazard_ctrl: load-use, load feeding a branch (two bubbles),
// ALU result and MEM load feeding a branch, memory freeze over an owed bubble,
// register 0 never matching, counter saturation and clear priority, and reset
// while a bubble is owed.

module tb_hazard_ctrl;

  localparam int CNT_W = 16;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic [4:0]       id_rs_i, id_rt_i, ex_rd_i, mem_rd_i;
  logic             id_branch_i, branch_taken_i;
  logic             ex_memread_i, ex_regwrite_i, mem_memread_i;
  logic             dmem_stall_i, clr_cnt_i;
  logic             pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o, pipe_stall_o;
  logic [CNT_W-1:0] stall_cnt_o, bubble_cnt_o, flush_cnt_o;

  int n_assert = 0;
  int n_fail   = 0;

  hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .id_rs_i        (id_rs_i),
    .id_rt_i        (id_rt_i),
    .id_branch_i    (id_branch_i),
    .branch_taken_i (branch_taken_i),
    .ex_memread_i   (ex_memread_i),
    .ex_regwrite_i  (ex_regwrite_i),
    .ex_rd_i        (ex_rd_i),
    .mem_memread_i  (mem_memread_i),
    .mem_rd_i       (mem_rd_i),
    .dmem_stall_i   (dmem_stall_i),
    .clr_cnt_i      (clr_cnt_i),
    .pc_write_o     (pc_write_o),
    .ifid_write_o   (ifid_write_o),
    .ifid_flush_o   (ifid_flush_o),
    .idex_bubble_o  (idex_bubble_o),
    .pipe_stall_o   (pipe_stall_o),
    .stall_cnt_o    (stall_cnt_o),
    .bubble_cnt_o   (bubble_cnt_o),
    .flush_cnt_o    (flush_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #5_000_000;
    $display("[TB] FAIL timeout: simulation did not finish in time");
    $fatal(1, "[TB] timeout");
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  // Checks all five control outputs in the order pc, ifid_write, flush, bubble, stall.
  task automatic check_ctrl(input string tag, input logic [4:0] exp);
    check_output({tag, ".pc_write"},     {31'd0, pc_write_o},    {31'd0, exp[4]});
    check_output({tag, ".ifid_write"},   {31'd0, ifid_write_o},  {31'd0, exp[3]});
    check_output({tag, ".ifid_flush"},   {31'd0, ifid_flush_o},  {31'd0, exp[2]});
    check_output({tag, ".idex_bubble"},  {31'd0, idex_bubble_o}, {31'd0, exp[1]});
    check_output({tag, ".pipe_stall"},   {31'd0, pipe_stall_o},  {31'd0, exp[0]});
  endtask

  task automatic check_cnt(input string tag, input int s, input int b, input int f);
    check_output({tag, ".stall_cnt"},  {16'd0, stall_cnt_o},  s);
    check_output({tag, ".bubble_cnt"}, {16'd0, bubble_cnt_o}, b);
    check_output({tag, ".flush_cnt"},  {16'd0, flush_cnt_o},  f);
  endtask

  task automatic apply_stimulus(input logic [4:0] rs, input logic [4:0] rt,
                                input logic br, input logic tk,
                                input logic exr, input logic exw, input logic [4:0] exd,
                                input logic memr, input logic [4:0] memd,
                                input logic dm, input logic clr);
    id_rs_i = rs; id_rt_i = rt; id_branch_i = br; branch_taken_i = tk;
    ex_memread_i = exr; ex_regwrite_i = exw; ex_rd_i = exd;
    mem_memread_i = memr; mem_rd_i = memd; dmem_stall_i = dm; clr_cnt_i = clr;
    #1;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Expected control patterns {pc, ifid_write, flush, bubble, stall}.
  localparam logic [4:0] C_RST    = 5'b00110;
  localparam logic [4:0] C_NORM   = 5'b11000;
  localparam logic [4:0] C_BUBBLE = 5'b00010;
  localparam logic [4:0] C_FLUSH  = 5'b11100;
  localparam logic [4:0] C_FREEZE = 5'b00001;

  initial begin
    $display("[TB] start");
    rst_i = 1'b0;
    apply_stimulus(5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 1'b0);
    check_ctrl("reset", C_RST);
    check_cnt("reset", 0, 0, 0);
    tick();
    apply_stimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    rst_i = 1'b1;
    #1;
    check_ctrl("idle", C_NORM);
    tick();

    // Load-use: lw $5 in EX, add $3,$5,$6 in ID.
    apply_stimulus(5'd5, 5'd6, 1'b0, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 1'b0);
    check_ctrl("lu", C_BUBBLE);
    tick();
    apply_stimulus(5'd5, 5'd6, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd5, 1'b0, 1'b0);
    check_ctrl("lu_after", C_NORM);
    check_cnt("lu", 0, 1, 0);
    tick();

    // Load feeding a taken branch: two bubbles, then the flush.
    apply_stimulus(5'd7, 5'd0, 1'b1, 1'b1, 1'b1, 1'b1, 5'd7, 1'b0, 5'd0, 1'b0, 1'b0);
    check_ctrl("lubr_run", C_BUBBLE);
    tick();
    apply_stimulus(5'd7, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 5'd7, 1'b0, 1'b0);
    check_ctrl("lubr_stall", C_BUBBLE);
    tick();
    apply_stimulus(5'd7, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    check_ctrl("lubr_flush", C_FLUSH);
    check_cnt("lubr_bubbles", 0, 3, 0);
    tick();
    apply_stimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    check_cnt("lubr_flush", 0, 3, 1);

    // Memory freeze arriving while a bubble is owed.
    apply_stimulus(5'd7, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd7, 1'b0, 5'd0, 1'b0, 1'b0);
    check_ctrl("frz_setup", C_BUBBLE);
    tick();
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(5'd7, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd7, 1'b1, 1'b0);
      check_ctrl($sformatf("frz_%0d", i), C_FREEZE);
      tick();
    end
    apply_stimulus(5'd7, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd7, 1'b0, 1'b0);
    check_ctrl("frz_owed", C_BUBBLE);
    check_cnt("frz_during", 4, 4, 1);
    tick();
    apply_stimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    check_ctrl("frz_done", C_NORM);
    check_cnt("frz_done", 4, 5, 1);

    // Register 0 never matches.
    apply_stimulus(5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0);
    check_ctrl("r0_a", C_NORM);
    tick();
    check_ctrl("r0_b", C_NORM);
    tick();
    check_cnt("r0", 4, 5, 1);

    // ALU result in EX feeding a taken branch: one bubble, taken ignored.
    apply_stimulus(5'd1, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1, 5'd3, 1'b0, 5'd0, 1'b0, 1'b0);
    check_ctrl("bex", C_BUBBLE);
    tick();
    // Load in MEM feeding a branch: one bubble.
    apply_stimulus(5'd4, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 5'd4, 1'b0, 1'b0);
    check_ctrl("bmem", C_BUBBLE);
    tick();
    // Single-bubble branch hazards leave the FSM in RUN: branch resolves now.
    apply_stimulus(5'd4, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b0, 1'b0);
    check_ctrl("bmem_after", C_FLUSH);
    tick();
    apply_stimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    check_cnt("branch_haz", 4, 7, 2);

    // Clear in the same cycle as a bubble.
    apply_stimulus(5'd5, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 1'b1);
    tick();
    check_cnt("clr", 0, 0, 0);

    // Saturation of the bubble counter.
    apply_stimulus(5'd5, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 1'b0);
    for (int i = 0; i < 65535; i++) tick();
    check_output("sat_reach", {16'd0, bubble_cnt_o}, 32'h0000_FFFF);
    check_ctrl("sat_hazard", C_BUBBLE);
    tick();
    check_output("sat_hold", {16'd0, bubble_cnt_o}, 32'h0000_FFFF);
    apply_stimulus(5'd5, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 1'b1);
    tick();
    check_cnt("sat_clr", 0, 0, 0);

    // Reset while a bubble is owed.
    apply_stimulus(5'd7, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd7, 1'b0, 5'd0, 1'b0, 1'b0);
    tick();
    apply_stimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    check_ctrl("pre_rst_stall", C_BUBBLE);
    check_cnt("pre_rst", 0, 1, 0);
    rst_i = 1'b0;
    #1;
    check_ctrl("rst_mid", C_RST);
    check_cnt("rst_mid", 0, 0, 0);
    tick();
    rst_i = 1'b1;
    #1;
    check_ctrl("rst_release", C_NORM);
    tick();
    check_ctrl("rst_run", C_NORM);
    check_cnt("rst_run", 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
